// File: rtl/neureka_wmem_responder_pkg.sv
// NEUREKA shared constants and the weight-memory response record.
// Used by the WMEM responder; see neureka_wmem_responder.sv for the NEUREKA_WMEM_ERR_EN option.
package neureka_package;

    localparam int NEUREKA_MEM_BANDWIDTH_EXT = 256;
    localparam int NEUREKA_WMEM_DEPTH        = 1024;
    localparam int NEUREKA_WMEM_ID_W         = 8;

    typedef struct packed {
        logic [NEUREKA_MEM_BANDWIDTH_EXT-1:0] data;
        logic [NEUREKA_WMEM_ID_W-1:0]         id;
        logic                                 opc;
    } wmem_resp_t;

    // A new request may only be granted while a response slot is guaranteed.
    function automatic logic wmem_credit_ok(input int unsigned used, input int unsigned depth);
        return used < depth;
    endfunction

endpackage

// File: rtl/neureka_wmem_responder_if.sv
// HCI core (TCDM-style) request/response bundle between a NEUREKA streamer and the WMEM.
interface neureka_wmem_responder_if
    import neureka_package::*;
#(
    parameter int DW = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int AW = 32,
    parameter int IW = NEUREKA_WMEM_ID_W
) ();

    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic [IW-1:0]   id;
    logic            r_valid;
    logic            r_ready;
    logic [DW-1:0]   r_data;
    logic [IW-1:0]   r_id;
    logic            r_opc;

    modport master (
        output req, add, wen, be, data, id, r_ready,
        input  gnt, r_valid, r_data, r_id, r_opc
    );

    modport slave (
        input  req, add, wen, be, data, id, r_ready,
        output gnt, r_valid, r_data, r_id, r_opc
    );

endinterface

// File: rtl/neureka_wmem_responder_fifo.sv
// In-order response FIFO with fall-through bypass: an incoming entry is presented in the
// same cycle when empty, and only stored if the consumer does not take it immediately.
module neureka_wmem_resp_fifo
    import neureka_package::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wmem_resp_t
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    input  T                             in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output T                             out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    T                mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            empty, full, push, pop;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign push        = in_valid_i & ~flush_i & ~(empty & out_ready_i);
    assign pop         = ~empty & out_ready_i & ~flush_i;
    assign out_valid_o = ~flush_i & (~empty | in_valid_i);
    assign count_o     = count_q;

    always_comb begin
        out_data_o = '0;
        if (out_valid_o) begin
            out_data_o = empty ? in_data_i : mem_q[rptr_q];
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
            if (pop)  rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= in_data_i;
    end

    // Upstream credit accounting must make this unreachable.
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

endmodule

// File: rtl/neureka_wmem_responder.sv
// WMEM target of the HCI core protocol: TCDM requests to a 1-cycle SRAM, credit-protected
// in-order responses. Define NEUREKA_WMEM_ERR_EN to flag out-of-range addresses with opc=1.
module neureka_wmem_responder
    import neureka_package::*;
#(
    parameter int DW         = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int AW         = 32,
    parameter int IW         = NEUREKA_WMEM_ID_W,
    parameter int MEM_DEPTH  = NEUREKA_WMEM_DEPTH,
    parameter int RESP_DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    neureka_wmem_responder_if.slave       tcdm,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr_o,
    output logic [DW/8-1:0]               mem_be_o,
    output logic [DW-1:0]                 mem_wdata_o,
    input  logic [DW-1:0]                 mem_rdata_i
);

    localparam int OFF = $clog2(DW / 8);
    localparam int IXW = $clog2(MEM_DEPTH);
    localparam int CW  = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          opc;
    } resp_t;

    logic [CW-1:0]  fifo_count;
    logic           inflight_q, inflight_d;
    logic           wr_q, wr_d;
    logic [IW-1:0]  id_q, id_d;
    logic           accept, in_range, mem_en, push_valid;
    logic [IXW-1:0] word_idx;
    resp_t          resp_in, resp_out;

    assign word_idx = tcdm.add[OFF +: IXW];

`ifdef NEUREKA_WMEM_ERR_EN
    logic err_q, err_d, err_flag_q, err_flag_d;
    logic unused_add;
    assign in_range   = (tcdm.add[AW-1:OFF+IXW] == '0);
    assign unused_add = ^tcdm.add[OFF-1:0];
`else
    logic unused_add;
    assign in_range   = 1'b1;
    assign unused_add = ^{tcdm.add[AW-1:OFF+IXW], tcdm.add[OFF-1:0]};
`endif

    // Credits count both stored responses and the one still in the SRAM pipeline.
    assign tcdm.gnt = tcdm.req & ~clear_i &
                      wmem_credit_ok(32'(fifo_count) + 32'(inflight_q), RESP_DEPTH);
    assign accept   = tcdm.req & tcdm.gnt;
    assign mem_en   = accept & in_range;

    assign mem_req_o   = mem_en;
    assign mem_we_o    = mem_en & ~tcdm.wen;
    assign mem_addr_o  = mem_en ? word_idx : '0;
    assign mem_be_o    = (mem_en & ~tcdm.wen) ? tcdm.be : '0;
    assign mem_wdata_o = (mem_en & ~tcdm.wen) ? tcdm.data : '0;

    always_comb begin
        inflight_d = accept;
        id_d       = id_q;
        wr_d       = wr_q;
        if (accept) begin
            id_d = tcdm.id;
            wr_d = ~tcdm.wen;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            id_q       <= '0;
            wr_q       <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            id_q       <= id_d;
            wr_q       <= wr_d;
        end
    end

`ifdef NEUREKA_WMEM_ERR_EN
    always_comb begin
        err_d      = err_q;
        if (accept) err_d = ~in_range;
        err_flag_d = clear_i ? 1'b0 : (err_flag_q | (accept & ~in_range));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
        end
    end

    a_err_sticky: assert property (@(posedge clk_i) disable iff (rst_i)
        (tcdm.r_valid && tcdm.r_opc) |-> err_flag_q);
`endif

    // SRAM data lands one cycle after the access; a clear in that cycle drops it.
    always_comb begin
        resp_in    = '0;
        resp_in.id = id_q;
`ifdef NEUREKA_WMEM_ERR_EN
        resp_in.opc = err_q;
        if (!wr_q && !err_q) resp_in.data = mem_rdata_i;
`else
        if (!wr_q) resp_in.data = mem_rdata_i;
`endif
    end

    assign push_valid = inflight_q & ~clear_i;

    neureka_wmem_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .T     (resp_t)
    ) i_resp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (clear_i),
        .in_valid_i  (push_valid),
        .in_data_i   (resp_in),
        .out_valid_o (tcdm.r_valid),
        .out_ready_i (tcdm.r_ready),
        .out_data_o  (resp_out),
        .count_o     (fifo_count)
    );

    assign tcdm.r_data = resp_out.data;
    assign tcdm.r_id   = resp_out.id;
    assign tcdm.r_opc  = resp_out.opc;

endmodule

// File: tb/tb_neureka_wmem_responder.sv
// Scoreboard bench for neureka_wmem_responder with a word-array reference model of the WMEM.
module tb_neureka_wmem_responder;
    import neureka_package::*;

    localparam int DW = 256, AW = 32, IW = 8, MEM_DEPTH = 1024, RESP_DEPTH = 2;
    localparam int BYTES = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          opc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst, clear;
    logic            mem_req, mem_we;
    logic [9:0]      mem_addr;
    logic [BYTES-1:0] mem_be;
    logic [DW-1:0]   mem_wdata, mem_rdata;

    neureka_wmem_responder_if #(.DW(DW), .AW(AW), .IW(IW)) tcdm ();

    neureka_wmem_responder #(
        .DW(DW), .AW(AW), .IW(IW), .MEM_DEPTH(MEM_DEPTH), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm(tcdm),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int   n_checks = 0, n_fail = 0;
    exp_t sbq[$];
    logic [DW-1:0] ref_mem [MEM_DEPTH];
    logic [DW-1:0] sram    [MEM_DEPTH];

    function automatic logic [DW-1:0] init_word(input int i);
        logic [DW-1:0] w;
        if (i == 2) return {32{8'hA5}};
        for (int k = 0; k < 8; k++) w[32*k +: 32] = 32'((i + 1) * 32'h9E3779B1) ^ 32'(k * 32'h01010101);
        return w;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single-port SRAM with one cycle read latency.
    initial for (int i = 0; i < MEM_DEPTH; i++) sram[i] = init_word(i);
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < BYTES; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // Reference: what the accepted request must return, from plain word/byte arithmetic.
    task automatic model_accept(input logic wen, input logic [AW-1:0] add, input logic [BYTES-1:0] be,
                                input logic [DW-1:0] wd, input logic [IW-1:0] id);
        int unsigned idx;
        exp_t e;
        idx    = (add / BYTES) % MEM_DEPTH;
        e.id   = id;
        e.opc  = 1'b0;
        e.data = '0;
`ifdef NEUREKA_WMEM_ERR_EN
        if (add >= MEM_DEPTH * BYTES) begin
            e.opc = 1'b1;
            check("mem_req_oob", mem_req, 0);
            sbq.push_back(e);
            return;
        end
`endif
        check("mem_req", mem_req, 1);
        check("mem_addr", mem_addr, idx);
        check("mem_we", mem_we, !wen);
        if (wen) e.data = ref_mem[idx];
        else for (int b = 0; b < BYTES; b++) if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        sbq.push_back(e);
    endtask

    // Drive a request (called at posedge+1) until granted; returns at posedge+1 after the accept edge.
    task automatic issue(input logic wen, input logic [AW-1:0] add, input logic [BYTES-1:0] be,
                         input logic [DW-1:0] wd, input logic [IW-1:0] id);
        int   waited = 0;
        logic done = 1'b0;
        tcdm.req = 1'b1; tcdm.wen = wen; tcdm.add = add; tcdm.be = be; tcdm.data = wd; tcdm.id = id;
        while (!done) begin
            @(negedge clk);
            if (tcdm.gnt) begin
                model_accept(wen, add, be, wd, id);
                done = 1'b1;
            end else if (++waited > 50) begin
                n_checks++; n_fail++;
                $display("FAIL grant_timeout: no gnt for add %h after %0d cycles", add, waited);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        tcdm.req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: grant rule, response order/content, and stability under back-pressure.
    int   outs = 0, resp_cnt = 0;
    logic stall_prev = 1'b0;
    exp_t held, got;
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt", tcdm.gnt, tcdm.req & ~clear & (outs < RESP_DEPTH));
            if (clear) begin
                check("r_valid_clear", tcdm.r_valid, 0);
                sbq.delete();
                outs = 0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", tcdm.r_valid, 1);
                    check("stall_data", tcdm.r_data, held.data);
                    check("stall_id", tcdm.r_id, held.id);
                    check("stall_opc", tcdm.r_opc, held.opc);
                end
                stall_prev = 1'b0;
                if (tcdm.r_valid) begin
                    if (sbq.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL spurious_resp: got id %h with nothing outstanding", tcdm.r_id);
                    end else if (tcdm.r_ready) begin
                        got = sbq.pop_front();
                        check("resp_data", tcdm.r_data, got.data);
                        check("resp_id", tcdm.r_id, got.id);
                        check("resp_opc", tcdm.r_opc, got.opc);
                        outs--;
                        resp_cnt++;
                    end else begin
                        stall_prev = 1'b1;
                        held = {tcdm.r_data, tcdm.r_id, tcdm.r_opc};
                    end
                end
                if (tcdm.req && tcdm.gnt) outs++;
            end
        end
    end

    logic rand_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_rdy) tcdm.r_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        logic [DW-1:0] w, rd;
        logic [AW-1:0] a;
        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_word(i);
        rst = 1'b1; clear = 1'b0;
        tcdm.req = 1'b0; tcdm.wen = 1'b1; tcdm.add = '0; tcdm.be = '0; tcdm.data = '0; tcdm.id = '0;
        tcdm.r_ready = 1'b0;

        @(negedge clk);
        check("rst_gnt", tcdm.gnt, 0);
        check("rst_r_valid", tcdm.r_valid, 0);
        check("rst_r_data", tcdm.r_data, 0);
        check("rst_r_id", tcdm.r_id, 0);
        check("rst_r_opc", tcdm.r_opc, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tcdm.r_ready = 1'b1;
        idle(2);

        // Single read of word 2 at byte address 0x40, 1-cycle latency.
        issue(1'b1, 32'h40, '0, '0, 8'h11);
        tcdm.req = 1'b0;
        @(negedge clk);
        check("single_valid", tcdm.r_valid, 1);
        check("single_data", tcdm.r_data, {32{8'hA5}});
        check("single_id", tcdm.r_id, 8'h11);
        @(posedge clk); #1;
        idle(1);

        // Back-to-back reads: one response per cycle.
        start = resp_cnt;
        issue(1'b1, 32'h00, '0, '0, 8'h01);
        issue(1'b1, 32'h20, '0, '0, 8'h02);
        issue(1'b1, 32'h40, '0, '0, 8'h03);
        tcdm.req = 1'b0;
        @(negedge clk); #1;
        check("b2b_count", resp_cnt - start, 3);
        @(posedge clk); #1;
        idle(2);

        // Credits exhausted with r_ready low.
        tcdm.r_ready = 1'b0;
        issue(1'b1, 32'h60, '0, '0, 8'h04);
        issue(1'b1, 32'h80, '0, '0, 8'h05);
        tcdm.req = 1'b1; tcdm.wen = 1'b1; tcdm.add = 32'hA0; tcdm.id = 8'h06;
        repeat (3) begin
            @(negedge clk);
            check("full_gnt", tcdm.gnt, 0);
        end
        @(posedge clk); #1;
        tcdm.r_ready = 1'b1;
        @(posedge clk); #1;
        tcdm.r_ready = 1'b0;
        issue(1'b1, 32'hA0, '0, '0, 8'h06);
        tcdm.r_ready = 1'b1;
        idle(4);

        // Partial write of word 5, then read it back.
        issue(1'b0, 32'(5 * BYTES), 32'h0000_00FF, {32{8'h11}}, 8'h07);
        issue(1'b1, 32'(5 * BYTES), '0, '0, 8'h08);
        idle(3);
        w = init_word(5);
        rd = sram[5];
        check("wr_bytes", rd, {w[DW-1:64], {8{8'h11}}});

        // Address one past the end of the memory.
        issue(1'b1, 32'(MEM_DEPTH * BYTES), '0, '0, 8'h09);
        idle(3);

        // Clear one cycle after an accepted read.
        issue(1'b1, 32'h60, '0, '0, 8'h0A);
        clear = 1'b1;
        tcdm.req = 1'b1; tcdm.wen = 1'b1; tcdm.add = 32'hC0; tcdm.id = 8'h0B;
        @(negedge clk);
        check("clr_gnt", tcdm.gnt, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        start = resp_cnt;
        issue(1'b1, 32'hC0, '0, '0, 8'h0B);
        idle(3);
        check("clr_next_resp", resp_cnt - start, 1);

        // Randomized traffic under random back-pressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [DW-1:0] d;
            if ($urandom_range(0, 3) == 0) idle(1);
            for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, MEM_DEPTH * BYTES - 1));
            issue($urandom_range(0, 9) < 7, a, $urandom, d, 8'($urandom));
        end
        tcdm.req = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        tcdm.r_ready = 1'b1;
        for (int t = 0; t < 50 && sbq.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
